// File: rtl/ddr3_arb_pkg.sv
// Shared widths, request payload and arbiter state encoding for the DDR3 port arbiter.
package ddr3_arb_pkg;

    localparam int unsigned RAM_DATA_W = 128;
    localparam int unsigned RAM_STRB_W = 16;
    localparam int unsigned RAM_ID_W   = 16;
    localparam int unsigned PORT_TAG_W = 4;
    localparam int unsigned PORT_ID_W  = 12;
    localparam int unsigned RAM_ADDR_W = 32;

    // Request payload presented to the core.
    typedef struct packed {
        logic [RAM_STRB_W-1:0] wr;
        logic                  rd;
        logic [RAM_ID_W-1:0]   id;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] data;
    } ram_req_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ddr3_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping modulo N.
module ddr3_rr_arb
    import ddr3_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int unsigned k;
        k       = 0;
        grant_c = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!valid_c && req_i[IW'(k)]) begin
                valid_c             = 1'b1;
                idx_c               = IW'(k);
                grant_c[IW'(k)]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_axi_port_arb.sv
// N-port round-robin arbiter in front of one DDR3 core: tags requests with the
// port index, routes responses back by tag, and limits outstanding requests per port.
module ddr3_axi_port_arb
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned PORTS           = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [PORTS*RAM_STRB_W-1:0]   inport_wr_i,
    input  logic [PORTS-1:0]              inport_rd_i,
    input  logic [PORTS*PORT_ID_W-1:0]    inport_req_id_i,
    input  logic [PORTS*RAM_ADDR_W-1:0]   inport_addr_i,
    input  logic [PORTS*RAM_DATA_W-1:0]   inport_write_data_i,
    output logic [PORTS-1:0]              inport_accept_o,
    output logic [PORTS-1:0]              inport_ack_o,
    output logic [PORTS-1:0]              inport_error_o,
    output logic [PORTS*RAM_DATA_W-1:0]   inport_read_data_o,
    output logic [PORTS*PORT_ID_W-1:0]    inport_resp_id_o,
    output logic [RAM_STRB_W-1:0]         outport_wr_o,
    output logic                          outport_rd_o,
    output logic [RAM_ID_W-1:0]           outport_req_id_o,
    output logic [RAM_ADDR_W-1:0]         outport_addr_o,
    output logic [RAM_DATA_W-1:0]         outport_write_data_o,
    input  logic                          outport_accept_i,
    input  logic                          outport_ack_i,
    input  logic                          outport_error_i,
    input  logic [RAM_DATA_W-1:0]         outport_read_data_i,
    input  logic [RAM_ID_W-1:0]           outport_resp_id_i,
    output logic                          protocol_err_o
);

    localparam int unsigned IDX_W = $clog2(PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  count_q [PORTS];
    logic [CNT_W-1:0]  count_d [PORTS];
    logic              protocol_err_q, protocol_err_d;

    logic [PORTS-1:0]      req_vec_c;
    logic [PORTS-1:0]      elig_c;
    logic [PORTS-1:0]      pick_grant_c;
    logic [IDX_W-1:0]      pick_idx_c;
    logic                  pick_valid_c;
    logic [PORTS-1:0]      sel_oh_c;
    logic [IDX_W-1:0]      sel_idx_c;
    logic                  sel_valid_c;
    ram_req_t              req_c;
    logic [PORT_TAG_W-1:0] tag_c;
    logic [PORTS-1:0]      ack_c;
    logic                  bad_ack_c;

    // Per-port request detection and credit-based eligibility.
    always_comb begin
        req_vec_c = '0;
        elig_c    = '0;
        for (int p = 0; p < PORTS; p++) begin
            req_vec_c[p] = (|inport_wr_i[p*RAM_STRB_W +: RAM_STRB_W]) | inport_rd_i[p];
            elig_c[p]    = req_vec_c[p] && (count_q[p] < CNT_MAX);
        end
    end

    ddr3_rr_arb #(
        .N (PORTS)
    ) u_rr_arb (
        .req_i   (elig_c),
        .ptr_i   (rr_ptr_q),
        .grant_c (pick_grant_c),
        .idx_c   (pick_idx_c),
        .valid_c (pick_valid_c)
    );

    // Lock FSM: hold a grant until the core accepts it; advance the pointer on accept.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        sel_oh_c    = pick_grant_c;
        sel_idx_c   = pick_idx_c;
        sel_valid_c = pick_valid_c;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_c && !outport_accept_i) begin
                    state_d = ST_LOCKED;
                    grant_d = pick_idx_c;
                end
            end
            ST_LOCKED: begin
                sel_idx_c          = grant_q;
                sel_valid_c        = req_vec_c[grant_q];
                sel_oh_c           = '0;
                sel_oh_c[grant_q]  = req_vec_c[grant_q];
                if (outport_accept_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rst_i) begin
            sel_oh_c    = '0;
            sel_valid_c = 1'b0;
        end
        if (sel_valid_c && outport_accept_i) begin
            rr_ptr_d = (sel_idx_c == IDX_W'(PORTS - 1)) ? '0 : sel_idx_c + IDX_W'(1);
        end
    end

    // Request mux towards the core and accept demux back to the granted port.
    always_comb begin
        req_c           = '0;
        inport_accept_o = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (sel_oh_c[p]) begin
                req_c.wr           = inport_wr_i[p*RAM_STRB_W +: RAM_STRB_W];
                req_c.rd           = inport_rd_i[p];
                req_c.id           = {PORT_TAG_W'(p), inport_req_id_i[p*PORT_ID_W +: PORT_ID_W]};
                req_c.addr         = inport_addr_i[p*RAM_ADDR_W +: RAM_ADDR_W];
                req_c.data         = inport_write_data_i[p*RAM_DATA_W +: RAM_DATA_W];
                inport_accept_o[p] = outport_accept_i;
            end
        end
    end

    assign outport_wr_o         = req_c.wr;
    assign outport_rd_o         = req_c.rd;
    assign outport_req_id_o     = req_c.id;
    assign outport_addr_o       = req_c.addr;
    assign outport_write_data_o = req_c.data;

    assign tag_c = outport_resp_id_i[RAM_ID_W-1 -: PORT_TAG_W];

    // Route an ack to its tagged port only if that port has something outstanding.
    always_comb begin
        ack_c     = '0;
        bad_ack_c = 1'b0;
        if (rst_i && outport_ack_i) begin
            bad_ack_c = 1'b1;
            for (int p = 0; p < PORTS; p++) begin
                if (tag_c == PORT_TAG_W'(p) && count_q[p] != '0) begin
                    ack_c[p]  = 1'b1;
                    bad_ack_c = 1'b0;
                end
            end
        end
    end

    assign inport_ack_o       = ack_c;
    assign inport_error_o     = ack_c & {PORTS{outport_error_i}};
    assign inport_resp_id_o   = rst_i ? {PORTS{outport_resp_id_i[PORT_ID_W-1:0]}} : '0;
    assign inport_read_data_o = rst_i ? {PORTS{outport_read_data_i}} : '0;
    assign protocol_err_o     = protocol_err_q;

    // Outstanding counters (accept increments, ack decrements) and sticky error.
    always_comb begin
        protocol_err_d = protocol_err_q | bad_ack_c;
        for (int p = 0; p < PORTS; p++) begin
            count_d[p] = count_q[p];
            if (inport_accept_o[p] && !ack_c[p] && count_q[p] < CNT_MAX) begin
                count_d[p] = count_q[p] + CNT_W'(1);
            end else if (ack_c[p] && !inport_accept_o[p]) begin
                count_d[p] = count_q[p] - CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= '0;
            protocol_err_q <= 1'b0;
            for (int p = 0; p < PORTS; p++) begin
                count_q[p] <= '0;
            end
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            protocol_err_q <= protocol_err_d;
            count_q        <= count_d;
        end
    end

endmodule

// File: tb/tb_ddr3_axi_port_arb.sv
// Directed bench for ddr3_axi_port_arb (4 ports, 2 credits per port).
module tb_ddr3_axi_port_arb;

    localparam int unsigned P  = 4;
    localparam int unsigned MO = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [P*16-1:0]   wr;
    logic [P-1:0]      rd;
    logic [P*12-1:0]   req_id;
    logic [P*32-1:0]   addr;
    logic [P*128-1:0]  wdata;
    logic [P-1:0]      accept_o;
    logic [P-1:0]      ack_o;
    logic [P-1:0]      error_o;
    logic [P*128-1:0]  rdata_o;
    logic [P*12-1:0]   resp_id_o;
    logic [15:0]       out_wr;
    logic              out_rd;
    logic [15:0]       out_id;
    logic [31:0]       out_addr;
    logic [127:0]      out_data;
    logic              acc;
    logic              ack;
    logic              err;
    logic [127:0]      rdata;
    logic [15:0]       rid;
    logic              perr;

    int total  = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    ddr3_axi_port_arb #(
        .PORTS           (P),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .inport_wr_i          (wr),
        .inport_rd_i          (rd),
        .inport_req_id_i      (req_id),
        .inport_addr_i        (addr),
        .inport_write_data_i  (wdata),
        .inport_accept_o      (accept_o),
        .inport_ack_o         (ack_o),
        .inport_error_o       (error_o),
        .inport_read_data_o   (rdata_o),
        .inport_resp_id_o     (resp_id_o),
        .outport_wr_o         (out_wr),
        .outport_rd_o         (out_rd),
        .outport_req_id_o     (out_id),
        .outport_addr_o       (out_addr),
        .outport_write_data_o (out_data),
        .outport_accept_i     (acc),
        .outport_ack_i        (ack),
        .outport_error_i      (err),
        .outport_read_data_i  (rdata),
        .outport_resp_id_i    (rid),
        .protocol_err_o       (perr)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        wr = '0; rd = '0; req_id = '0; addr = '0; wdata = '0;
        acc = 1'b0; ack = 1'b0; err = 1'b0; rdata = '0; rid = '0;
    endtask

    task automatic set_rd(input int p, input logic [11:0] id, input logic [31:0] a);
        rd[p] = 1'b1;
        req_id[p*12 +: 12] = id;
        addr[p*32 +: 32] = a;
    endtask

    task automatic set_wr(input int p, input logic [15:0] s, input logic [11:0] id,
                          input logic [31:0] a, input logic [127:0] d);
        wr[p*16 +: 16] = s;
        req_id[p*12 +: 12] = id;
        addr[p*32 +: 32] = a;
        wdata[p*128 +: 128] = d;
    endtask

    task automatic drop(input int p);
        rd[p] = 1'b0;
        wr[p*16 +: 16] = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk_i);
        clear_inputs();
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
    endtask

    initial begin
        // Reset state with live inputs
        clear_inputs();
        rst_i = 1'b0;
        #3;
        set_rd(1, 12'h055, 32'h40);
        acc = 1'b1; ack = 1'b1; rid = 16'h1001; rdata = '1;
        #1;
        check("rst_accept", 128'(accept_o), 128'h0);
        check("rst_out_rd", 128'(out_rd), 128'h0);
        check("rst_out_id", 128'(out_id), 128'h0);
        check("rst_ack", 128'(ack_o), 128'h0);
        check("rst_rdata", rdata_o[127:0], 128'h0);
        check("rst_perr", 128'(perr), 128'h0);
        @(negedge clk_i);
        clear_inputs();
        rst_i = 1'b1;

        // Basic read on port 2
        @(negedge clk_i);
        set_rd(2, 12'h0AB, 32'h100);
        acc = 1'b1;
        #1;
        check("basic_req_id", 128'(out_id), 128'h20AB);
        check("basic_addr", 128'(out_addr), 128'h100);
        check("basic_rd", 128'(out_rd), 128'h1);
        check("basic_accept", 128'(accept_o), 128'h4);
        @(negedge clk_i);
        clear_inputs();
        ack = 1'b1; rid = 16'h20AB;
        rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        #1;
        check("basic_ack", 128'(ack_o), 128'h4);
        check("basic_resp_id", 128'(resp_id_o[2*12 +: 12]), 128'h0AB);
        check("basic_rdata", rdata_o[2*128 +: 128], 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
        check("basic_err", 128'(error_o), 128'h0);
        @(negedge clk_i);
        clear_inputs();
        #1;
        check("basic_perr", 128'(perr), 128'h0);

        // Round-robin: all ports, accept every cycle, until credits run out
        reset_pulse();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                for (int p = 0; p < 4; p++) set_rd(p, 12'(16 + p), 32'(p * 64));
                acc = 1'b1;
            end
            #1;
            check($sformatf("rr_tag%0d", c), 128'(out_id[15:12]), 128'(c % 4));
            check($sformatf("rr_acc%0d", c), 128'(accept_o), 128'(1 << (c % 4)));
        end
        @(negedge clk_i);
        #1;
        check("rr_exhausted_acc", 128'(accept_o), 128'h0);
        check("rr_exhausted_rd", 128'(out_rd), 128'h0);

        // Grant lock on port 1 while port 0 joins
        reset_pulse();
        @(negedge clk_i);
        set_rd(1, 12'h111, 32'h1000);
        #1;
        check("lock_first_tag", 128'(out_id[15:12]), 128'h1);
        check("lock_first_acc", 128'(accept_o), 128'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            set_rd(0, 12'h000, 32'h0800);
            #1;
            check($sformatf("lock_hold_tag%0d", i), 128'(out_id[15:12]), 128'h1);
            check($sformatf("lock_hold_addr%0d", i), 128'(out_addr), 128'h1000);
        end
        @(negedge clk_i);
        acc = 1'b1;
        #1;
        check("lock_accept1", 128'(accept_o), 128'h2);
        @(negedge clk_i);
        drop(1);
        #1;
        check("lock_then_p0_acc", 128'(accept_o), 128'h1);
        check("lock_then_p0_tag", 128'(out_id[15:12]), 128'h0);

        // Credit limit of 2 on port 0
        reset_pulse();
        @(negedge clk_i);
        set_wr(0, 16'hFFFF, 12'h001, 32'h2000, 128'h1234);
        acc = 1'b1;
        #1;
        check("credit_w1", 128'(accept_o), 128'h1);
        @(negedge clk_i);
        #1;
        check("credit_w2", 128'(accept_o), 128'h1);
        @(negedge clk_i);
        #1;
        check("credit_w3_blocked", 128'(accept_o), 128'h0);
        check("credit_w3_outwr", 128'(out_wr), 128'h0);
        @(negedge clk_i);
        ack = 1'b1; rid = 16'h0001;
        #1;
        check("credit_ack", 128'(ack_o), 128'h1);
        check("credit_ack_cycle_acc", 128'(accept_o), 128'h0);
        @(negedge clk_i);
        ack = 1'b0;
        #1;
        check("credit_w3_granted", 128'(accept_o), 128'h1);
        check("credit_w3_outwr2", 128'(out_wr), 128'hFFFF);

        // Simultaneous accept and ack on port 3
        reset_pulse();
        @(negedge clk_i);
        set_rd(3, 12'h333, 32'h3000);
        acc = 1'b1;
        #1;
        check("sim_first_acc", 128'(accept_o), 128'h8);
        @(negedge clk_i);
        ack = 1'b1; rid = 16'h3333; err = 1'b1;
        #1;
        check("sim_acc", 128'(accept_o), 128'h8);
        check("sim_ack", 128'(ack_o), 128'h8);
        check("sim_err", 128'(error_o), 128'h8);
        @(negedge clk_i);
        ack = 1'b0; err = 1'b0;
        #1;
        check("sim_count_one_acc", 128'(accept_o), 128'h8);
        @(negedge clk_i);
        #1;
        check("sim_count_full", 128'(accept_o), 128'h0);

        // Bad acks: out-of-range tag, and a tag with nothing outstanding
        @(negedge clk_i);
        clear_inputs();
        ack = 1'b1; rid = 16'h5000;
        #1;
        check("bad_tag_ack", 128'(ack_o), 128'h0);
        check("bad_tag_perr_pre", 128'(perr), 128'h0);
        @(negedge clk_i);
        rid = 16'h1000;
        #1;
        check("bad_zero_cnt_ack", 128'(ack_o), 128'h0);
        check("bad_tag_perr", 128'(perr), 128'h1);
        @(negedge clk_i);
        ack = 1'b0;
        @(negedge clk_i);
        #1;
        check("bad_perr_sticky", 128'(perr), 128'h1);

        // Async reset with requests outstanding
        reset_pulse();
        #1;
        check("ar_perr_cleared", 128'(perr), 128'h0);
        @(negedge clk_i);
        set_rd(0, 12'h00A, 32'hA0);
        set_rd(1, 12'h00B, 32'hB0);
        set_rd(2, 12'h00C, 32'hC0);
        acc = 1'b1;
        #1;
        check("ar_acc0", 128'(accept_o), 128'h1);
        @(negedge clk_i);
        #1;
        check("ar_acc1", 128'(accept_o), 128'h2);
        @(negedge clk_i);
        #1;
        check("ar_acc2", 128'(accept_o), 128'h4);
        @(negedge clk_i);
        ack = 1'b1; rid = 16'h000A; rdata = 128'h77;
        #1;
        check("ar_pre_ack", 128'(ack_o), 128'h1);
        rst_i = 1'b0;
        #1;
        check("ar_accept", 128'(accept_o), 128'h0);
        check("ar_out_rd", 128'(out_rd), 128'h0);
        check("ar_out_id", 128'(out_id), 128'h0);
        check("ar_ack", 128'(ack_o), 128'h0);
        check("ar_resp_id", 128'(resp_id_o), 128'h0);
        check("ar_rdata", rdata_o[127:0], 128'h0);
        clear_inputs();
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        ack = 1'b1; rid = 16'h100B;
        #1;
        check("ar_old_ack", 128'(ack_o), 128'h0);
        @(negedge clk_i);
        ack = 1'b0;
        #1;
        check("ar_old_perr", 128'(perr), 128'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
